// File: rtl/pico_out_port_deco.sv
// PicoBlaze output-port decoder: latches RTC address/data/config bytes and
// launches read/write transactions, tracking each until done or timeout.
module pico_out_port_deco #(
  parameter logic [7:0]  PORT_DIR  = 8'h01,
  parameter logic [7:0]  PORT_DATO = 8'h02,
  parameter logic [7:0]  PORT_CMD  = 8'h03,
  parameter logic [7:0]  PORT_CFG  = 8'h04,
  parameter logic [15:0] TIMEOUT   = 16'd2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       listo_lee,
  input  logic       listo_escribe,
  output logic [7:0] dir_rtc,
  output logic [7:0] dato_rtc,
  output logic [7:0] cfg,
  output logic       inicia_lee,
  output logic       inicia_escribe,
  output logic       ocupado,
  output logic       error,
  output logic       fin_trans
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEE     = 2'd1,
    ESCRIBE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        lee_d, esc_d, fin_d, err_d;
  logic        cmd_hit, done;

  assign cmd_hit = write_strobe && (port_id == PORT_CMD);
  assign done    = ((state_q == LEE) && listo_lee) ||
                   ((state_q == ESCRIBE) && listo_escribe);
  assign ocupado = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lee_d   = 1'b0;
    esc_d   = 1'b0;
    fin_d   = 1'b0;
    err_d   = error;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (cmd_hit) begin
          case (out_port)
            8'h01: begin
              lee_d   = 1'b1;
              state_d = LEE;
            end
            8'h02: begin
              esc_d   = 1'b1;
              state_d = ESCRIBE;
            end
            8'h00: err_d = 1'b0;
            default: ;
          endcase
        end
      end
      LEE, ESCRIBE: begin
        // Completion takes priority over a timeout landing on the same edge.
        if (done) begin
          fin_d   = 1'b1;
          cnt_d   = 16'd0;
          state_d = IDLE;
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          err_d   = 1'b1;
          cnt_d   = 16'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 16'd0;
      inicia_lee     <= 1'b0;
      inicia_escribe <= 1'b0;
      fin_trans      <= 1'b0;
      error          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      inicia_lee     <= lee_d;
      inicia_escribe <= esc_d;
      fin_trans      <= fin_d;
      error          <= err_d;
    end
  end

  // Operand registers are frozen while a transaction is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_rtc  <= 8'h00;
      dato_rtc <= 8'h00;
      cfg      <= 8'h00;
    end else if (write_strobe) begin
      if (port_id == PORT_DIR && state_q == IDLE)
        dir_rtc <= out_port;
      if (port_id == PORT_DATO && state_q == IDLE)
        dato_rtc <= out_port;
      if (port_id == PORT_CFG)
        cfg <= out_port;
    end
  end

endmodule

// File: doc/pico_out_port_deco.md
Name: pico_out_port_deco

Overview:
- PicoBlaze output-port decoder and RTC transaction launcher; write-direction counterpart of the input-side status mux/register.
- Decodes port_id/out_port/write_strobe into the address, data and config registers for the RTC bus controller.
- Issues one-cycle read/write start pulses and tracks each transaction until the controller's done flag or a timeout.
- Exports ocupado/error/fin_trans so the input mux can return them to the PicoBlaze.

Parameters:
PORT_DIR, 8'h01, port_id of the RTC address register
PORT_DATO, 8'h02, port_id of the RTC write-data register
PORT_CMD, 8'h03, port_id of the command register
PORT_CFG, 8'h04, port_id of the configuration register
TIMEOUT, 16'd2000, maximum cycles spent in LEE/ESCRIBE before abort

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
port_id  input  8  PicoBlaze port address
out_port  input  8  PicoBlaze output data
write_strobe  input  1  PicoBlaze write qualifier, one cycle
listo_lee  input  1  controller: read transaction done
listo_escribe  input  1  controller: write transaction done
dir_rtc  output  8  registered RTC register address
dato_rtc  output  8  registered RTC write data
cfg  output  8  registered configuration byte
inicia_lee  output  1  one-cycle read start pulse
inicia_escribe  output  1  one-cycle write start pulse
ocupado  output  1  high while a transaction is in flight
error  output  1  sticky timeout flag
fin_trans  output  1  one-cycle pulse on successful completion

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, state IDLE, timeout counter 0. Applies mid-transaction: abort immediately with no fin_trans and no error.
- Decode hit: write_strobe=1 && port_id==PORT_x. Effects are visible the cycle after the strobe edge (1-cycle latency). Unmatched port_id has no effect.
- DIR/DATO writes:
  - Load only in IDLE.
  - Ignored while ocupado=1, so operands stay stable for the controller.
- CFG writes: load in any state.
- CMD values, accepted only in IDLE:
  - 8'h01: inicia_lee=1 for exactly one cycle; state to LEE.
  - 8'h02: inicia_escribe=1 for exactly one cycle; state to ESCRIBE.
  - 8'h00: clears error.
  - Other values: no effect.
- States:
  - IDLE: ocupado=0. listo_lee/listo_escribe are ignored.
  - LEE: ocupado=1. Counter increments each cycle. listo_lee=1 -> fin_trans pulse, counter 0, IDLE. listo_escribe is ignored.
  - ESCRIBE: same as LEE, completing on listo_escribe only.
- ocupado rises in the same cycle as the start pulse and falls in the same cycle as fin_trans.
- Timeout:
  - If the counter reaches TIMEOUT-1 with no matching listo: error=1, IDLE, no fin_trans.
  - If listo arrives on the same edge as the timeout condition, listo wins: fin_trans, no error.
- error is sticky. A new command may be launched with error=1; error is cleared only by CMD 8'h00 or rst.
- Any CMD write while in LEE/ESCRIBE is dropped, including 8'h00.
- A CMD strobe on the same edge that listo completes a transaction is evaluated against the pre-edge state (busy) and is dropped.
- Back-to-back: a new command can be accepted starting the cycle after fin_trans.
- Start pulses never overlap. At most one of inicia_lee/inicia_escribe is high in any cycle.

Test Plan:
1. Reset then write DIR=8'h21, DATO=8'h59, CFG=8'h80 -> one cycle later dir_rtc=8'h21, dato_rtc=8'h59, cfg=8'h80; ocupado=0, error=0.
2. CMD=8'h01 at cycle t -> inicia_lee=1 only at t+1, ocupado=1 from t+1; listo_lee at t+10 -> fin_trans=1 at t+11, ocupado=0 at t+11.
3. During ESCRIBE, write DIR=8'hFF and CMD=8'h01 -> dir_rtc unchanged, no inicia_lee; listo_lee pulse ignored; listo_escribe completes the transaction.
4. TIMEOUT=16 override, CMD=8'h02 with no listo -> after 16 cycles error=1, ocupado=0, no fin_trans; CMD=8'h00 -> error=0 next cycle.
5. listo_lee on the exact timeout edge -> fin_trans=1, error stays 0; rst asserted mid-LEE -> all outputs 0 next cycle, later listo ignored.
6. CMD=8'h07 and write to port_id 8'h10 -> no pulses, no register change; CMD=8'h01 immediately after fin_trans -> accepted.
